// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone KPG prefix adder with valid/ready flow control and a sideband tag.
// Optional subtract mode (adds port in_sub) is enabled by defining PREFIX_ADDER_SUB_EN.
module prefix_adder_pipe #(
   parameter int WIDTH            = 24,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int TAG_W            = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef PREFIX_ADDER_SUB_EN
   input  logic             in_sub,
`endif
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int LVL = $clog2(WIDTH);
   localparam int NG  = (LVL + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
   localparam int NW  = 2 * WIDTH;

   localparam logic [1:0] KPG_K = 2'b00;
   localparam logic [1:0] KPG_P = 2'b01;
   localparam logic [1:0] KPG_G = 2'b10;

   function automatic logic [1:0] kpg_gen(input logic a, input logic b);
      logic [1:0] r;
      case ({a, b})
         2'b11:   r = KPG_G;
         2'b00:   r = KPG_K;
         default: r = KPG_P;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] kpg_cell(input logic [1:0] upper, input logic [1:0] lower);
      logic [1:0] r;
      if (upper == KPG_P) r = lower;
      else                r = upper;
      return r;
   endfunction

   // Applies the prefix levels lo..hi-1; level lv combines each node with the one 2^lv below it.
   function automatic logic [NW-1:0] prefix_group(input logic [NW-1:0] nodes, input int lo, input int hi);
      logic [NW-1:0] cur;
      logic [NW-1:0] nxt;
      logic [NW-1:0] sh;
      cur = nodes;
      for (int lv = 0; lv < LVL; lv++) begin
         nxt = cur;
         sh  = cur << (2 * (1 << lv));
         if ((lv >= lo) && (lv < hi)) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (i >= (1 << lv)) nxt[2*i +: 2] = kpg_cell(cur[2*i +: 2], sh[2*i +: 2]);
               else                nxt[2*i +: 2] = cur[2*i +: 2];
            end
         end else begin
            nxt = cur;
         end
         cur = nxt;
      end
      return cur;
   endfunction

   logic             advance_s;
   logic             accept_s;
   logic             sub_s;
   logic [WIDTH-1:0] b_eff_s;
   logic             cin_eff_s;
   logic [WIDTH-1:0] gen_p_s;
   logic [NW-1:0]    gen_nodes_s;
   logic [1:0]       gen_top_s;
   logic [NW-1:0]    nodes_s [NG];
   logic [WIDTH-1:0] carry_s;
   logic             cout_s;
   logic [WIDTH:0]   sum_s;

   // valid_r[NG] is the output register's valid bit; valid_r[g] feeds prefix group g
   logic [NG:0]      valid_r;
   logic [WIDTH-1:0] p_r     [NG];
   logic [NW-1:0]    nodes_r [NG];
   logic [1:0]       top_r   [NG];
   logic [TAG_W-1:0] tag_r   [NG];
   logic [WIDTH:0]   out_sum_r;
   logic [TAG_W-1:0] out_tag_r;

`ifdef PREFIX_ADDER_SUB_EN
   assign sub_s = in_sub;
`else
   assign sub_s = 1'b0;
`endif

   assign advance_s = ~valid_r[NG] | out_ready;
   assign accept_s  = in_valid & advance_s;
   assign in_ready  = advance_s;
   assign out_valid = valid_r[NG];
   assign busy      = |valid_r;
   assign out_sum   = out_sum_r;
   assign out_tag   = out_tag_r;

   // Stage 0 KPG generation; node 0 is the carry-in, the top bit's KPG is kept aside for carry-out
   always_comb begin
      b_eff_s     = in_b;
      cin_eff_s   = in_cin;
      gen_nodes_s = '0;
      if (sub_s) begin
         b_eff_s   = ~in_b;
         cin_eff_s = 1'b1;
      end else begin
         b_eff_s   = in_b;
         cin_eff_s = in_cin;
      end
      gen_p_s = in_a ^ b_eff_s;
      if (cin_eff_s) gen_nodes_s[1:0] = KPG_G;
      else           gen_nodes_s[1:0] = KPG_K;
      for (int i = 1; i < WIDTH; i++) begin
         gen_nodes_s[2*i +: 2] = kpg_gen(in_a[i-1], b_eff_s[i-1]);
      end
      gen_top_s = kpg_gen(in_a[WIDTH-1], b_eff_s[WIDTH-1]);
   end

   // Prefix levels evaluated between pipeline registers
   always_comb begin
      for (int g = 0; g < NG; g++) begin
         nodes_s[g] = prefix_group(nodes_r[g], g * LEVELS_PER_STAGE, (g + 1) * LEVELS_PER_STAGE);
      end
   end

   // Resolved prefix nodes are all K or G; carry-out folds in the top bit's own KPG
   always_comb begin
      carry_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         carry_s[i] = (nodes_s[NG-1][2*i +: 2] == KPG_G);
      end
      cout_s = (kpg_cell(top_r[NG-1], nodes_s[NG-1][2*(WIDTH-1) +: 2]) == KPG_G);
      sum_s  = {cout_s, p_r[NG-1] ^ carry_s};
   end

   // Whole-pipeline advance; the output register only loads real results so it holds across bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= '0;
         for (int g = 0; g < NG; g++) begin
            p_r[g]     <= '0;
            nodes_r[g] <= '0;
            top_r[g]   <= KPG_K;
            tag_r[g]   <= '0;
         end
         out_sum_r <= '0;
         out_tag_r <= '0;
      end else if (advance_s) begin
         valid_r    <= {valid_r[NG-1:0], accept_s};
         p_r[0]     <= gen_p_s;
         nodes_r[0] <= gen_nodes_s;
         top_r[0]   <= gen_top_s;
         tag_r[0]   <= in_tag;
         for (int g = 1; g < NG; g++) begin
            p_r[g]     <= p_r[g-1];
            nodes_r[g] <= nodes_s[g-1];
            top_r[g]   <= top_r[g-1];
            tag_r[g]   <= tag_r[g-1];
         end
         if (valid_r[NG-1]) begin
            out_sum_r <= sum_s;
            out_tag_r <= tag_r[NG-1];
         end else begin
            out_sum_r <= out_sum_r;
            out_tag_r <= out_tag_r;
         end
      end else begin
         valid_r <= valid_r;
      end
   end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe at default parameters (WIDTH=24, N=4).
module tb_prefix_adder_pipe;

   localparam int WIDTH = 24;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out_sum;
   logic [TAG_W-1:0] out_tag;
   logic             busy;
`ifdef PREFIX_ADDER_SUB_EN
   logic             in_sub;
`endif

   int errors = 0;
   int checks = 0;

   prefix_adder_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef PREFIX_ADDER_SUB_EN
      .in_sub    (in_sub),
`endif
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [TAG_W-1:0] tag;
      logic [WIDTH:0]   sum;
   } vec_t;

   vec_t vecs [10];

   logic [WIDTH-1:0] sa [50];
   logic [WIDTH-1:0] sb [50];
   logic             sc [50];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [TAG_W-1:0] tag);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_tag   = tag;
`ifdef PREFIX_ADDER_SUB_EN
      in_sub   = sub;
`else
      if (sub) $display("note: subtract request ignored in add-only build");
`endif
   endtask

   // Issue one op into an empty pipeline and measure latency in cycles
   task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input logic [TAG_W-1:0] tag,
                         input logic [WIDTH:0] exp);
      int lat;
      @(negedge clk);
      drive(1'b1, a, b, cin, sub, tag);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 20);
      check({name, " latency"}, 32'(lat), 32'd4);
      check({name, " sum"}, 32'(out_sum), 32'(exp));
      check({name, " tag"}, 32'(out_tag), 32'(tag));
   endtask

   initial begin
      int stale;
      logic exp_v;

      vecs[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 4'h3, 25'h1000000};
      vecs[1] = '{24'h123456, 24'h654321, 1'b1, 4'h5, 25'h0777778};
      vecs[2] = '{24'h000000, 24'h000000, 1'b1, 4'h1, 25'h0000001};
      vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'hF, 25'h1FFFFFF};
      vecs[4] = '{24'h000000, 24'h000000, 1'b0, 4'h0, 25'h0000000};
      vecs[5] = '{24'h800000, 24'h800000, 1'b0, 4'h7, 25'h1000000};
      vecs[6] = '{24'hAAAAAA, 24'h555555, 1'b0, 4'hA, 25'h0FFFFFF};
      vecs[7] = '{24'hAAAAAA, 24'h555555, 1'b1, 4'hB, 25'h1000000};
      vecs[8] = '{24'h000F0F, 24'h0000F1, 1'b0, 4'h2, 25'h0001000};
      vecs[9] = '{24'h7FFFFF, 24'h000001, 1'b0, 4'hC, 25'h0800000};

      // reset values, with out_ready low to show in_ready does not follow it in reset
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_sum", 32'(out_sum), 32'd0);
      check("rst out_tag", 32'(out_tag), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].tag, vecs[i].sum);
      end

`ifdef PREFIX_ADDER_SUB_EN
      run_op("sub 5-7", 24'h000005, 24'h000007, 1'b0, 1'b1, 4'h6, 25'h0FFFFFE);
      run_op("sub 7-5", 24'h000007, 24'h000005, 1'b0, 1'b1, 4'h8, 25'h1000002);
`endif

      // streaming: 50 back-to-back ops, results expected on 50 consecutive cycles
      for (int i = 0; i < 50; i++) begin
         sa[i] = WIDTH'($urandom);
         sb[i] = WIDTH'($urandom);
         sc[i] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 55; k++) begin
         @(negedge clk);
         exp_v = (k >= 4) && (k < 54);
         check($sformatf("stream valid k=%0d", k), 32'(out_valid), 32'(exp_v));
         if (exp_v) begin
            check($sformatf("stream sum %0d", k - 4), 32'(out_sum),
                  32'({1'b0, sa[k-4]} + {1'b0, sb[k-4]} + 25'(sc[k-4])));
            check($sformatf("stream tag %0d", k - 4), 32'(out_tag), 32'((k - 4) % 16));
         end
         check($sformatf("stream in_ready k=%0d", k), 32'(in_ready), 32'd1);
         if (k < 50) drive(1'b1, sa[k], sb[k], sc[k], 1'b0, TAG_W'(k % 16));
         else        in_valid = 1'b0;
      end
      check("stream busy drained", 32'(busy), 32'd0);

      // backpressure: A,B,C in, output stalled 3 cycles, D offered during the stall
      out_ready = 1'b0;
      @(negedge clk); drive(1'b1, 24'h000001, 24'h000002, 1'b0, 1'b0, 4'h1);
      @(negedge clk); drive(1'b1, 24'h100000, 24'h200000, 1'b0, 1'b0, 4'h2);
      @(negedge clk); drive(1'b1, 24'hFFFFFF, 24'h000010, 1'b0, 1'b0, 4'h3);
      @(negedge clk); in_valid = 1'b0;
      check("bp empty before A", 32'(out_valid), 32'd0);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check($sformatf("bp stall%0d valid", s), 32'(out_valid), 32'd1);
         check($sformatf("bp stall%0d sum", s), 32'(out_sum), 32'h0000003);
         check($sformatf("bp stall%0d tag", s), 32'(out_tag), 32'h1);
         check($sformatf("bp stall%0d in_ready", s), 32'(in_ready), 32'd0);
         check($sformatf("bp stall%0d busy", s), 32'(busy), 32'd1);
         if (s == 0) drive(1'b1, 24'hABCDEF, 24'h123456, 1'b1, 1'b0, 4'h4);
         if (s == 2) out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp B valid", 32'(out_valid), 32'd1);
      check("bp B sum", 32'(out_sum), 32'h0300000);
      check("bp B tag", 32'(out_tag), 32'h2);
      @(negedge clk);
      check("bp C sum", 32'(out_sum), 32'h100000F);
      check("bp C tag", 32'(out_tag), 32'h3);
      @(negedge clk);
      check("bp bubble valid", 32'(out_valid), 32'd0);
      check("bp bubble holds sum", 32'(out_sum), 32'h100000F);
      check("bp bubble holds tag", 32'(out_tag), 32'h3);
      @(negedge clk);
      check("bp D valid", 32'(out_valid), 32'd1);
      check("bp D sum", 32'(out_sum), 32'h0BE0246);
      check("bp D tag", 32'(out_tag), 32'h4);
      @(negedge clk);
      check("bp drained valid", 32'(out_valid), 32'd0);
      check("bp drained busy", 32'(busy), 32'd0);

      // reset with three ops in flight
      @(negedge clk); drive(1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0, 4'h5);
      @(negedge clk); drive(1'b1, 24'h333333, 24'h444444, 1'b0, 1'b0, 4'h6);
      @(negedge clk); drive(1'b1, 24'h555555, 24'h666666, 1'b0, 1'b0, 4'h7);
      @(negedge clk);
      in_valid = 1'b0;
      check("mid busy before rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst out_sum", 32'(out_sum), 32'd0);
      check("mid rst out_tag", 32'(out_tag), 32'd0);
      check("mid rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 24'h000100, 24'h000200, 1'b0, 1'b0, 4'h9);
      stale = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) stale++;
      end
      check("post rst no stale", 32'(stale), 32'd0);
      @(negedge clk);
      check("post rst E valid", 32'(out_valid), 32'd1);
      check("post rst E sum", 32'(out_sum), 32'h0000300);
      check("post rst E tag", 32'(out_tag), 32'h9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
